uart_btn_msg_tx: RTL and testbench
==================================

UART_BTN_MSG_TX -- requirements
Module: uart_btn_msg_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk_i cycles per UART bit; legal range 2 or more.
REQ-002 SHALL have parameter NUM_BUTTONS, default 4: button inputs and messages; legal range 1-8.
REQ-003 SHALL have parameter MSG_LEN, default 4: bytes per message; legal range 1-16.
REQ-004 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5-8.
REQ-005 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port button_i, input, NUM_BUTTONS bits: message requests, synchronous to clk_i.
REQ-009 SHALL have port uart_tx_data_o, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port uart_tx_active_o, output, 1 bit: high while a message is being transmitted.
REQ-011 SHALL have port uart_tx_done_o, output, 1 bit: one-cycle pulse after the last stop bit of a message.

Function
REQ-012 SHALL register button_i each cycle; trigger vector = button_i & ~previous sample (rising edge only); a held button SHALL NOT retrigger.
REQ-013 SHALL select the lowest-index set trigger bit when several bits rise in the same cycle; other simultaneous triggers are discarded.
REQ-014 SHALL define message byte k of button b as (8'h30 + b*MSG_LEN + k), truncated to the DATA_BITS LSBs.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, NEXT; PARITY is reachable only per REQ-027.
REQ-016 From IDLE, a trigger at clock edge E SHALL drive uart_tx_data_o low and uart_tx_active_o high from edge E+1 (start bit).
REQ-017 Each bit SHALL last exactly CLKS_PER_BIT cycles; data SHALL be sent LSB first; stop bits SHALL be high.
REQ-018 Bytes of one message SHALL be sent back-to-back, with no idle cycles between the stop bit and the next start bit.
REQ-019 After the last stop bit, the FSM SHALL enter IDLE, drop uart_tx_active_o and pulse uart_tx_done_o high for exactly one cycle.
REQ-020 A trigger arriving while not IDLE SHALL be stored in a one-entry pending register if the register is empty, and dropped otherwise.
REQ-021 A stored pending request SHALL start its start bit on the cycle after IDLE is entered, giving exactly one cycle of uart_tx_active_o low.
REQ-022 Internal bit, byte and baud counters SHALL wrap to 0 at their terminal counts; no counter SHALL overflow its width for legal parameters.

Reset
REQ-023 While rst_n_i is low, outputs SHALL immediately be uart_tx_data_o=1, uart_tx_active_o=0 and uart_tx_done_o=0.
REQ-024 Reset SHALL clear the FSM to IDLE, clear all counters and the pending register, and set the button history to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; no partial frame SHALL resume after release.
REQ-026 A button held high across reset release SHALL produce exactly one message.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, each frame SHALL carry one even-parity bit after the data and before the stop bits (frame = 1+DATA_BITS+1+STOP_BITS bits).
REQ-028 Without UART_TX_PARITY_EN, no parity bit and no PARITY state SHALL exist (frame = 1+DATA_BITS+STOP_BITS bits).

Verification (CLKS_PER_BIT=4, NUM_BUTTONS=4, MSG_LEN=2, DATA_BITS=8, STOP_BITS=1, no parity unless stated)
REQ-029 Reset with button_i=0 -> uart_tx_data_o=1, uart_tx_active_o=0, uart_tx_done_o=0, and the line stays idle.
REQ-030 Pulse button_i=4'b0001 -> bytes 0x30,0x31; 40 cycles per byte; uart_tx_active_o high for exactly 80 cycles; one uart_tx_done_o pulse.
REQ-031 button_i=4'b1010 in a single cycle -> only 0x32,0x33 are sent; no second message follows.
REQ-032 button_i=4'b0100 is sent; press 4'b0001 then 4'b1000 during its first byte -> 0x34,0x35, then 1 cycle active low, then 0x30,0x31; the 4'b1000 request is dropped.
REQ-033 rst_n_i low for 3 cycles mid-data-bit of 0x30 -> line high immediately; after release, no transmission until a new button edge.
REQ-034 UART_TX_PARITY_EN defined, button 4'b0001 -> byte 0x31 carries parity bit 1 and 0x30 carries 0; frame is 44 cycles.

Source files
------------

// File: rtl/uart_btn_msg_tx.sv
// uart_btn_msg_tx: button-triggered UART message transmitter.
//
// A rising edge on any button_i bit sends a fixed MSG_LEN-byte message over an
// 8N1-style serial line. Byte k of button b is 8'h30 + b*MSG_LEN + k, truncated
// to DATA_BITS. A trigger that arrives while a message is in flight is held in a
// one-entry pending slot and sent after a single idle cycle.
//
// Optional feature macro: UART_TX_PARITY_EN -- adds one even-parity bit per frame.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_n_i          asynchronous active-low reset
//   button_i         message request lines, synchronous to clk_i
//   uart_tx_data_o   serial output, idle high
//   uart_tx_active_o high while a message is being sent
//   uart_tx_done_o   one-cycle pulse after the last stop bit of a message
module uart_btn_msg_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned NUM_BUTTONS  = 4,
  parameter int unsigned MSG_LEN      = 4,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_BUTTONS-1:0] button_i,
  output logic                   uart_tx_data_o,
  output logic                   uart_tx_active_o,
  output logic                   uart_tx_done_o
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned ByteW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  localparam logic [CntW-1:0]  BaudLast    = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  BaudPreLast = CntW'(CLKS_PER_BIT - 2);
  localparam logic [ByteW-1:0] ByteLast    = ByteW'(MSG_LEN - 1);
  localparam logic [2:0]       BitLast     = 3'(DATA_BITS - 1);
  localparam logic             StopLast    = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop,
    StNext
  } state_e;

  state_e                 r_state;
  logic [NUM_BUTTONS-1:0] r_btn_hist;
  logic                   r_pend_vld;
  logic [2:0]             r_pend_idx;
  logic [2:0]             r_btn_idx;
  logic [ByteW-1:0]       r_byte_idx;
  logic [CntW-1:0]        r_baud;
  logic [2:0]             r_bit;
  logic                   r_stop;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_tx;
  logic                   r_active;
  logic                   r_done;
`ifdef UART_TX_PARITY_EN
  logic                   r_par;
`endif

  logic [NUM_BUTTONS-1:0] w_trig;
  logic                   w_trig_any;
  logic [2:0]             w_trig_idx;
  logic [2:0]             w_idle_idx;

  function automatic logic [DATA_BITS-1:0] msg_byte(input logic [2:0]       b,
                                                    input logic [ByteW-1:0] k);
    logic [7:0] v;
    v = 8'h30 + 8'(b) * 8'(MSG_LEN) + 8'(k);
    return v[DATA_BITS-1:0];
  endfunction

  // Rising-edge detect; lowest index wins among simultaneous edges.
  always_comb begin
    w_trig     = button_i & ~r_btn_hist;
    w_trig_any = |w_trig;
    w_trig_idx = '0;
    for (int i = int'(NUM_BUTTONS) - 1; i >= 0; i--) begin
      if (w_trig[i]) w_trig_idx = 3'(i);
    end
    // A stored request takes precedence over a fresh one when leaving idle.
    w_idle_idx = r_pend_vld ? r_pend_idx : w_trig_idx;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= StIdle;
      r_btn_hist <= '0;
      r_pend_vld <= 1'b0;
      r_pend_idx <= '0;
      r_btn_idx  <= '0;
      r_byte_idx <= '0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_stop     <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_btn_hist <= button_i;
      r_done     <= 1'b0;

      // Busy: keep the first request that arrives, drop any after it.
      if (r_state != StIdle && w_trig_any && !r_pend_vld) begin
        r_pend_vld <= 1'b1;
        r_pend_idx <= w_trig_idx;
      end

      unique case (r_state)
        StIdle: begin
          if (r_pend_vld || w_trig_any) begin
            r_state    <= StStart;
            r_btn_idx  <= w_idle_idx;
            r_byte_idx <= '0;
            r_shift    <= msg_byte(w_idle_idx, '0);
`ifdef UART_TX_PARITY_EN
            r_par      <= ^msg_byte(w_idle_idx, '0);
`endif
            r_baud     <= '0;
            r_tx       <= 1'b0;
            r_active   <= 1'b1;
          end
          // Consuming the slot frees it for a trigger seen on this same edge.
          if (r_pend_vld) begin
            r_pend_vld <= w_trig_any;
            r_pend_idx <= w_trig_idx;
          end
        end

        StStart: begin
          if (r_baud == BaudLast) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= StData;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        StData: begin
          if (r_baud == BaudLast) begin
            r_baud <= '0;
            if (r_bit == BitLast) begin
              r_bit <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= StParity;
              r_tx    <= r_par;
`else
              r_state <= StStop;
              r_stop  <= 1'b0;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (r_baud == BaudLast) begin
            r_baud  <= '0;
            r_state <= StStop;
            r_stop  <= 1'b0;
            r_tx    <= 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif

        // The final cycle of the last stop bit is spent in StNext, so the next
        // start bit (or the return to idle) lands with no gap.
        StStop: begin
          if (r_stop == StopLast && r_baud == BaudPreLast) begin
            r_state <= StNext;
            r_baud  <= BaudLast;
          end else if (r_baud == BaudLast) begin
            r_baud <= '0;
            r_stop <= r_stop + 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        StNext: begin
          r_baud <= '0;
          r_stop <= 1'b0;
          if (r_byte_idx == ByteLast) begin
            r_state    <= StIdle;
            r_byte_idx <= '0;
            r_tx       <= 1'b1;
            r_active   <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_state    <= StStart;
            r_byte_idx <= r_byte_idx + ByteW'(1);
            r_shift    <= msg_byte(r_btn_idx, r_byte_idx + ByteW'(1));
`ifdef UART_TX_PARITY_EN
            r_par      <= ^msg_byte(r_btn_idx, r_byte_idx + ByteW'(1));
`endif
            r_tx       <= 1'b0;
          end
        end

        default: begin
          r_state  <= StIdle;
          r_tx     <= 1'b1;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx_data_o   = r_tx;
  assign uart_tx_active_o = r_active;
  assign uart_tx_done_o   = r_done;

endmodule

// File: tb/tb_uart_btn_msg_tx.sv
// Testbench for uart_btn_msg_tx. A reference model computes the expected line,
// active and done traces from button schedules at message granularity.
`timescale 1ns/1ps
module tb_uart_btn_msg_tx;

  localparam int CPB = 4;
  localparam int NB  = 4;
  localparam int ML  = 2;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = 1 + DB + PB + SB;
  localparam int PER   = FRAME * CPB;
  localparam int L     = ML * PER;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] button = '0;
  logic          tx, act, done;

  always #5 clk = ~clk;

  uart_btn_msg_tx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BUTTONS (NB),
    .MSG_LEN     (ML),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .button_i        (button),
    .uart_tx_data_o  (tx),
    .uart_tx_active_o(act),
    .uart_tx_done_o  (done)
  );

  int total = 0;
  int bad   = 0;

  logic [NB-1:0] sched[$];
  logic          obs_tx[$], obs_act[$], obs_done[$];
  bit            e_tx[], e_act[], e_done[];
  logic [7:0]    dec_b[$];
  logic          dec_p[$];
  int            dec_s[$];
  int            first_err;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1);
  end

  // Expected line level j cycles into a message for button b.
  function automatic bit model_bit(input int b, input int j);
    int m, pos;
    logic [7:0] v;
    m   = j / PER;
    pos = (j % PER) / CPB;
    v   = 8'(8'h30 + b * ML + m);
    if (pos == 0) return 1'b0;
    if (pos <= DB) return v[pos-1];
    if (PB == 1 && pos == DB + 1) return ^v[DB-1:0];
    return 1'b1;
  endfunction

  // Observation k is taken before the edge that sees sched[k].
  task automatic build_model();
    int n, busy, pend, b, st;
    logic [NB-1:0] prev, trig;
    n = sched.size();
    e_tx = new[n + L + 2];
    e_act = new[n + L + 2];
    e_done = new[n + L + 2];
    foreach (e_tx[i]) begin
      e_tx[i] = 1'b1; e_act[i] = 1'b0; e_done[i] = 1'b0;
    end
    busy = -1; pend = -1; prev = '0;
    for (int k = 0; k < n; k++) begin
      trig = sched[k] & ~prev;
      prev = sched[k];
      b = -1;
      for (int i = NB - 1; i >= 0; i--) if (trig[i]) b = i;
      if (k > busy) begin
        st = (pend >= 0) ? pend : b;
        if (pend >= 0) pend = b;
        if (st >= 0) begin
          for (int j = 1; j <= L; j++) begin
            e_act[k+j] = 1'b1;
            e_tx[k+j]  = model_bit(st, j - 1);
          end
          e_done[k+L+1] = 1'b1;
          busy = k + L;
        end
      end else if (b >= 0 && pend < 0) begin
        pend = b;
      end
    end
  endtask

  function automatic int trace_errs();
    int e;
    e = 0; first_err = -1;
    for (int i = 0; i < obs_tx.size(); i++) begin
      if (obs_tx[i] !== logic'(e_tx[i]) || obs_act[i] !== logic'(e_act[i]) ||
          obs_done[i] !== logic'(e_done[i])) begin
        if (first_err < 0) first_err = i;
        e++;
      end
    end
    return e;
  endfunction

  // Independent UART receiver: samples each bit mid-period from the line.
  task automatic decode();
    int i;
    logic [7:0] v;
    dec_b.delete(); dec_p.delete(); dec_s.delete();
    i = 1;
    while (i + PER <= obs_tx.size()) begin
      if (obs_tx[i-1] === 1'b1 && obs_tx[i] === 1'b0) begin
        v = '0;
        for (int d = 0; d < DB; d++) v[d] = obs_tx[i + CPB * (1 + d) + CPB / 2];
        dec_b.push_back(v);
        dec_p.push_back(obs_tx[i + CPB * (1 + DB) + CPB / 2]);
        dec_s.push_back(i);
        i += PER;
      end else begin
        i++;
      end
    end
  endtask

  task automatic do_reset(input logic [NB-1:0] hold);
    @(negedge clk);
    rst_n  = 1'b0;
    button = hold;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_sched();
    obs_tx.delete(); obs_act.delete(); obs_done.delete();
    foreach (sched[k]) begin
      obs_tx.push_back(tx);
      obs_act.push_back(act);
      obs_done.push_back(done);
      button = sched[k];
      @(negedge clk);
    end
    build_model();
    decode();
  endtask

  task automatic fill(input logic [NB-1:0] v, input int n);
    for (int i = 0; i < n; i++) sched.push_back(v);
  endtask

  task automatic test_reset();
    int e;
    @(negedge clk);
    button = '0;
    rst_n  = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b required 1", tx); end
    total++; if (act !== 1'b0) begin bad++; $display("FAIL reset_active: got %b required 0", act); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sched.delete(); fill('0, 40);
    run_sched();
    e = trace_errs();
    total++;
    if (e !== 0) begin
      bad++; $display("FAIL reset_idle_trace: %0d bad cycles (first %0d), required 0", e, first_err);
    end
  endtask

  task automatic test_single_press();
    int e, na, nd;
    do_reset('0);
    sched.delete(); fill(4'b0001, 1); fill('0, L + 20);
    run_sched();
    e = trace_errs();
    total++;
    if (e !== 0) begin
      bad++; $display("FAIL single_trace: %0d bad cycles (first %0d), required 0", e, first_err);
    end
    na = 0; nd = 0;
    foreach (obs_act[i]) begin
      if (obs_act[i] === 1'b1) na++;
      if (obs_done[i] === 1'b1) nd++;
    end
    total++; if (na !== L) begin bad++; $display("FAIL single_active_len: got %0d required %0d", na, L); end
    total++; if (nd !== 1) begin bad++; $display("FAIL single_done_pulses: got %0d required 1", nd); end
    total++;
    if (dec_b.size() != 2 || dec_b[0] !== 8'h30 || dec_b[1] !== 8'h31) begin
      bad++; $display("FAIL single_bytes: got %0d bytes first=%h required 30 31", dec_b.size(),
                      (dec_b.size() > 0) ? dec_b[0] : 8'hxx);
    end
    total++;
    if (dec_s.size() < 2 || dec_s[1] - dec_s[0] !== PER) begin
      bad++; $display("FAIL single_byte_period: got %0d required %0d",
                      (dec_s.size() < 2) ? -1 : dec_s[1] - dec_s[0], PER);
    end
`ifdef UART_TX_PARITY_EN
    total++;
    if (dec_p.size() < 2 || dec_p[0] !== 1'b0 || dec_p[1] !== 1'b1) begin
      bad++; $display("FAIL parity_bits: got %0d entries, required 0 then 1", dec_p.size());
    end
`endif
  endtask

  task automatic test_simultaneous();
    int e;
    do_reset('0);
    sched.delete(); fill(4'b1010, 1); fill('0, L + 40);
    run_sched();
    e = trace_errs();
    total++;
    if (e !== 0) begin
      bad++; $display("FAIL simul_trace: %0d bad cycles (first %0d), required 0", e, first_err);
    end
    total++;
    if (dec_b.size() != 2 || dec_b[0] !== 8'h32 || dec_b[1] !== 8'h33) begin
      bad++; $display("FAIL simul_bytes: got %0d bytes, required exactly 32 33", dec_b.size());
    end
  endtask

  task automatic test_back_to_back();
    int e;
    do_reset('0);
    sched.delete();
    fill(4'b0100, 1); fill('0, 4); fill(4'b0001, 1); fill('0, 9); fill(4'b1000, 1);
    fill('0, 2 * L + 30);
    run_sched();
    e = trace_errs();
    total++;
    if (e !== 0) begin
      bad++; $display("FAIL b2b_trace: %0d bad cycles (first %0d), required 0", e, first_err);
    end
    total++;
    if (dec_b.size() != 4 || dec_b[0] !== 8'h34 || dec_b[1] !== 8'h35 ||
        dec_b[2] !== 8'h30 || dec_b[3] !== 8'h31) begin
      bad++; $display("FAIL b2b_bytes: got %0d bytes, required 34 35 30 31", dec_b.size());
    end
    total++;
    if (obs_act[L+1] !== 1'b0) begin
      bad++; $display("FAIL b2b_gap_low: got %b required 0", obs_act[L+1]);
    end
    total++;
    if (obs_act[L] !== 1'b1 || obs_act[L+2] !== 1'b1) begin
      bad++; $display("FAIL b2b_gap_width: got %b/%b required 1/1", obs_act[L], obs_act[L+2]);
    end
  endtask

  task automatic test_held_across_reset();
    int e;
    do_reset(4'b0001);
    sched.delete(); fill(4'b0001, 3 * L);
    run_sched();
    e = trace_errs();
    total++;
    if (e !== 0) begin
      bad++; $display("FAIL held_trace: %0d bad cycles (first %0d), required 0", e, first_err);
    end
    total++;
    if (dec_b.size() != 2 || dec_b[0] !== 8'h30 || dec_b[1] !== 8'h31) begin
      bad++; $display("FAIL held_bytes: got %0d bytes, required exactly 30 31", dec_b.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int e;
    do_reset('0);
    sched.delete(); fill(4'b0001, 1); fill('0, 11);
    run_sched();
    rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrst_tx: got %b required 1", tx); end
    total++; if (act !== 1'b0) begin bad++; $display("FAIL midrst_active: got %b required 0", act); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b required 0", done); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sched.delete(); fill('0, L + 40);
    run_sched();
    e = trace_errs();
    total++;
    if (e !== 0) begin
      bad++; $display("FAIL midrst_idle_trace: %0d bad cycles (first %0d), required 0", e, first_err);
    end
    sched.delete(); fill(4'b0001, 1); fill('0, L + 10);
    run_sched();
    total++;
    if (dec_b.size() != 2 || dec_b[0] !== 8'h30 || dec_b[1] !== 8'h31) begin
      bad++; $display("FAIL midrst_resume_bytes: got %0d bytes, required 30 31", dec_b.size());
    end
  endtask

  task automatic test_random();
    int e, seg;
    logic [NB-1:0] v;
    for (int r = 0; r < 8; r++) begin
      do_reset('0);
      sched.delete();
      while (sched.size() < 500) begin
        seg = $urandom_range(1, 60);
        v = ($urandom_range(0, 9) < 6) ? '0 : NB'($urandom_range(1, 15));
        fill(v, seg);
      end
      run_sched();
      e = trace_errs();
      total++;
      if (e !== 0) begin
        bad++; $display("FAIL random_trace[%0d]: %0d bad cycles (first %0d), required 0", r, e,
                        first_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous();
    test_back_to_back();
    test_held_across_reset();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
